router_input_arbiter: RTL and testbench
=======================================

// Module: router_input_arbiter
//
// PURPOSE
//  Round-robin N:1 arbiter with a registered output stage. It sits directly upstream of routerVRTL.
//  It merges p_ninputs independent valid/ready message streams into the single valid/message_in/ready_out
//  stream the router consumes. Messages pass through unmodified: the MSB address field selects the router output.
//  Fairness: a continuously-valid input is granted at least once every p_ninputs accepted transfers.
//
// PARAMETERS
//  p_nbits    32  width of every message; equals routerVRTL p_nbits
//  p_ninputs  4   number of upstream input streams; >= 2; need not be a power of two
//
// PORTS
//  clk          in   1                    rising-edge clock
//  reset        in   1                    synchronous, active-high reset
//  valid_in     in   p_ninputs            per-input message valid
//  message_in   in   [p_nbits-1:0] x p_ninputs   per-input message (unpacked array, index = input id)
//  ready_out    out  p_ninputs            per-input ready; high on at most one bit per cycle
//  valid_out    out  1                    output register holds a message (drives router valid)
//  message_out  out  p_nbits              held message (drives router message_in)
//  ready_in     in   1                    downstream ready (router ready_out)
//  grant_id     out  $clog2(p_ninputs)    input id of the message currently in the output register
//
// BEHAVIOUR
//  - Reset values: valid_out=0, message_out=0, grant_id=0, priority pointer ptr=0.
//    ready_out is forced to all-zero in any cycle where reset=1.
//  - Transfer rule: a transfer on any side occurs when valid & ready are both high at a rising edge.
//    Inputs hold valid and message stable until accepted. valid_out, once high, stays high with message_out
//    stable until ready_in=1.
//  - Grant (combinational): g = first index i with valid_in[i]=1, scanning ptr, ptr+1, ...,
//    p_ninputs-1, 0, ..., ptr-1. No valid input means no grant.
//  - can_load = !valid_out | ready_in. This gives a combinational ready path from ready_in; an empty slot
//    or a same-cycle drain both allow a load.
//  - ready_out[i] = !reset & can_load & (a grant exists) & (i == g). All other bits are 0.
//  - On load (grant exists & can_load & !reset), at the next edge:
//      message_out <= message_in[g], grant_id <= g, valid_out <= 1
//      ptr <= g+1, or 0 when g == p_ninputs-1 (wrap-around)
//  - Drain without load (valid_out & ready_in & no grant): valid_out <= 0.
//    message_out and grant_id hold their last values.
//  - Simultaneous drain and load: the new message replaces the old one in the same edge, with no bubble.
//    Sustained throughput is 1 message/cycle.
//  - Latency: input accept edge -> valid_out high in the following cycle (1 cycle).
//  - Stall (valid_out & !ready_in): all ready_out=0, the register holds, and ptr holds.
//  - ptr changes only on a load. An unaccepted valid input never loses its priority position.
//  - Reset mid-operation: a held message is discarded, valid_out=0 on the cycle after reset,
//    and ptr returns to 0.
//  - Implementation: grant search is a rotated priority encoder or a doubled-vector search. ptr and grant_id
//    are $clog2(p_ninputs) bits; a non-power-of-two p_ninputs wraps explicitly at p_ninputs-1.
//
// TESTING
//  1. Reset: assert reset 2 cycles with all valid_in=1 -> ready_out=0 during reset;
//     valid_out=0, message_out=0, grant_id=0 after.
//  2. Single input: valid_in=4'b0100, msg[2]=32'hA000_0001, ready_in=1 -> ready_out=4'b0100;
//     next cycle valid_out=1, message_out=32'hA000_0001, grant_id=2.
//  3. Round robin: all 4 inputs valid continuously, ready_in=1 -> grant_id sequence
//     0,1,2,3,0,1 on consecutive cycles, valid_out never drops.
//  4. Backpressure: output full, ready_in=0 for 5 cycles with inputs 1,3 valid -> ready_out=0,
//     message_out stable. Raise ready_in -> drain and load of input 1 in the same edge, then input 3.
//  5. Wrap/skip: ptr=3 (after grant 2), only input 1 valid -> grant 1, ptr becomes 2.
//     With p_ninputs=3, a grant of 2 -> ptr 0.
//  6. Reset mid-op: valid_out=1, ready_in=0, pulse reset 1 cycle -> valid_out=0 after;
//     first post-reset grant is the lowest valid index.

Source files
------------

// File: rtl/router_input_arbiter.sv
// Round-robin N:1 arbiter that merges independent valid/ready message streams into one
// registered valid/ready stream for the router, with same-edge drain-and-reload for full throughput.
module router_input_arbiter #(
    parameter int p_nbits   = 32,
    parameter int p_ninputs = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [p_ninputs-1:0]         valid_in,
    input  logic [p_nbits-1:0]           message_in [p_ninputs],
    output logic [p_ninputs-1:0]         ready_out,
    output logic                         valid_out,
    output logic [p_nbits-1:0]           message_out,
    input  logic                         ready_in,
    output logic [$clog2(p_ninputs)-1:0] grant_id
);

    localparam int IW  = $clog2(p_ninputs);
    localparam int IW1 = IW + 1;
    localparam logic [IW-1:0] LAST_ID = IW'(p_ninputs - 1);
    localparam logic [IW:0]   NIN     = IW1'(p_ninputs);

    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;
    logic          can_load;
    logic          load;
    logic [IW:0]   scan_idx;

    // Rotated priority search: scanning from the highest offset down lets the
    // offset closest to ptr overwrite, so it wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = p_ninputs - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + IW1'(k);
            if (scan_idx >= NIN) begin
                scan_idx = scan_idx - NIN;
            end
            if (valid_in[scan_idx[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx[IW-1:0];
            end
        end
    end

    // An empty output register, or one draining on this edge, may accept a new message.
    always_comb begin
        can_load = !valid_out || ready_in;
        load     = !reset && can_load && grant_valid;
    end

    always_comb begin
        ready_out = '0;
        for (int i = 0; i < p_ninputs; i++) begin
            ready_out[i] = load && (grant_idx == IW'(i));
        end
    end

    // ptr only advances on a load, so a waiting input keeps its turn across stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out   <= 1'b0;
            message_out <= '0;
            grant_id    <= '0;
            ptr         <= '0;
        end else if (load) begin
            valid_out   <= 1'b1;
            message_out <= message_in[grant_idx];
            grant_id    <= grant_idx;
            ptr         <= (grant_idx == LAST_ID) ? '0 : grant_idx + IW'(1);
        end else if (valid_out && ready_in) begin
            valid_out   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_router_input_arbiter.sv
// Directed self-checking bench for router_input_arbiter: a 4-input instance plus a
// 3-input instance to exercise pointer wrap at a non-power-of-two size.
module tb_router_input_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  valid_in;
    logic [31:0] msg [4];
    logic [3:0]  ready_out;
    logic        valid_out;
    logic [31:0] message_out;
    logic        ready_in;
    logic [1:0]  grant_id;

    logic [2:0]  valid3;
    logic [31:0] msg3 [3];
    logic [2:0]  ready3;
    logic        valid_out3;
    logic [31:0] message_out3;
    logic [1:0]  grant_id3;

    int checks = 0;
    int errors = 0;

    router_input_arbiter #(.p_nbits(32), .p_ninputs(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .message_in(msg),
        .ready_out(ready_out), .valid_out(valid_out), .message_out(message_out),
        .ready_in(ready_in), .grant_id(grant_id)
    );

    router_input_arbiter #(.p_nbits(32), .p_ninputs(3)) dut3 (
        .clk(clk), .reset(reset), .valid_in(valid3), .message_in(msg3),
        .ready_out(ready3), .valid_out(valid_out3), .message_out(message_out3),
        .ready_in(ready_in), .grant_id(grant_id3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] vin, input logic [2:0] v3,
                                 input logic rdy, input logic rst);
        valid_in = vin;
        valid3   = v3;
        ready_in = rdy;
        reset    = rst;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) msg[i] = 32'hC0DE_0000 + i;
        for (int i = 0; i < 3; i++) msg3[i] = 32'hBEEF_0000 + i;

        // reset with every input requesting
        applyStimulus(4'b1111, 3'b111, 1'b1, 1'b1);
        checkOutput("rst_ready_a", 32'(ready_out), 32'h0);
        step();
        checkOutput("rst_ready_b", 32'(ready_out), 32'h0);
        checkOutput("rst_ready3", 32'(ready3), 32'h0);
        step();
        checkOutput("rst_valid_out", 32'(valid_out), 32'h0);
        checkOutput("rst_message_out", message_out, 32'h0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'h0);
        applyStimulus(4'b0000, 3'b000, 1'b1, 1'b0);
        step();
        checkOutput("idle_valid_out", 32'(valid_out), 32'h0);

        // single input
        msg[2] = 32'hA000_0001;
        applyStimulus(4'b0100, 3'b000, 1'b1, 1'b0);
        checkOutput("single_ready", 32'(ready_out), 32'h4);
        step();
        applyStimulus(4'b0000, 3'b000, 1'b1, 1'b0);
        checkOutput("single_valid", 32'(valid_out), 32'h1);
        checkOutput("single_msg", message_out, 32'hA000_0001);
        checkOutput("single_grant", 32'(grant_id), 32'h2);
        step();
        checkOutput("single_drain", 32'(valid_out), 32'h0);
        msg[2] = 32'hC0DE_0002;

        applyStimulus(4'b0000, 3'b000, 1'b1, 1'b1);
        step();

        // round robin, all valid, ends holding input 3 with ptr=0
        applyStimulus(4'b1111, 3'b000, 1'b1, 1'b0);
        checkOutput("rr_first_ready", 32'(ready_out), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput($sformatf("rr_grant_%0d", i), 32'(grant_id), 32'(i % 4));
            checkOutput($sformatf("rr_valid_%0d", i), 32'(valid_out), 32'h1);
            checkOutput($sformatf("rr_msg_%0d", i), message_out, 32'hC0DE_0000 + 32'(i % 4));
        end

        // backpressure with inputs 1 and 3 waiting
        applyStimulus(4'b1010, 3'b000, 1'b0, 1'b0);
        checkOutput("bp_ready_start", 32'(ready_out), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("bp_ready_%0d", i), 32'(ready_out), 32'h0);
            checkOutput($sformatf("bp_msg_%0d", i), message_out, 32'hC0DE_0003);
            checkOutput($sformatf("bp_valid_%0d", i), 32'(valid_out), 32'h1);
        end
        applyStimulus(4'b1010, 3'b000, 1'b1, 1'b0);
        checkOutput("bp_release_ready", 32'(ready_out), 32'h2);
        step();
        checkOutput("bp_grant_1", 32'(grant_id), 32'h1);
        checkOutput("bp_msg_1", message_out, 32'hC0DE_0001);
        checkOutput("bp_valid_1", 32'(valid_out), 32'h1);
        applyStimulus(4'b1000, 3'b000, 1'b1, 1'b0);
        checkOutput("bp_ready_3", 32'(ready_out), 32'h8);
        step();
        checkOutput("bp_grant_3", 32'(grant_id), 32'h3);
        applyStimulus(4'b0000, 3'b000, 1'b1, 1'b0);
        step();
        checkOutput("bp_drain_valid", 32'(valid_out), 32'h0);
        checkOutput("bp_drain_grant_hold", 32'(grant_id), 32'h3);
        checkOutput("bp_drain_msg_hold", message_out, 32'hC0DE_0003);

        // wrap/skip: grant 2 -> ptr 3, only input 1 -> grant 1, ptr 2
        applyStimulus(4'b0100, 3'b100, 1'b1, 1'b0);
        checkOutput("n3_ready_2", 32'(ready3), 32'h4);
        step();
        checkOutput("skip_grant_2", 32'(grant_id), 32'h2);
        checkOutput("n3_grant_2", 32'(grant_id3), 32'h2);
        applyStimulus(4'b0010, 3'b011, 1'b1, 1'b0);
        checkOutput("skip_ready_1", 32'(ready_out), 32'h2);
        checkOutput("n3_wrap_ready", 32'(ready3), 32'h1);
        step();
        checkOutput("skip_grant_1", 32'(grant_id), 32'h1);
        checkOutput("n3_wrap_grant", 32'(grant_id3), 32'h0);
        applyStimulus(4'b1010, 3'b000, 1'b1, 1'b0);
        checkOutput("skip_ptr2_ready", 32'(ready_out), 32'h8);
        step();
        checkOutput("skip_ptr2_grant", 32'(grant_id), 32'h3);
        applyStimulus(4'b0000, 3'b000, 1'b1, 1'b0);
        step();

        // reset mid-operation with a held message and ptr=3
        applyStimulus(4'b0100, 3'b000, 1'b1, 1'b0);
        step();
        applyStimulus(4'b1010, 3'b000, 1'b0, 1'b0);
        checkOutput("midrst_held", 32'(valid_out), 32'h1);
        checkOutput("midrst_stall_ready", 32'(ready_out), 32'h0);
        applyStimulus(4'b1010, 3'b000, 1'b1, 1'b1);
        checkOutput("midrst_ready_in_reset", 32'(ready_out), 32'h0);
        step();
        applyStimulus(4'b1010, 3'b000, 1'b1, 1'b0);
        checkOutput("midrst_valid_out", 32'(valid_out), 32'h0);
        checkOutput("midrst_msg", message_out, 32'h0);
        checkOutput("midrst_grant", 32'(grant_id), 32'h0);
        checkOutput("midrst_first_ready", 32'(ready_out), 32'h2);
        step();
        checkOutput("midrst_first_grant", 32'(grant_id), 32'h1);
        checkOutput("midrst_first_msg", message_out, 32'hC0DE_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
